fetch_decode_alu: RTL and testbench
===================================

# fetch_decode_alu

Three-stage integer front end: fetch, decode and execute for the processor core. Fetch reads 32-bit instructions from an internal instruction ROM at a program counter. Decode reads a 32x32 register file. A combinational ALU computes the result, which is written back to the register file. Pipeline registers separate fetch/decode and decode/execute, and a single global `enable` stalls the whole block.

## Interface
- `IMEM_DEPTH`, 256: instruction ROM depth in 32-bit words; must be a power of two.
- `IMEM_INIT`, "": hex file loaded into the ROM at elaboration; empty means all words are 0 (NOP).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `enable`  in  1  1 = pipeline advances; 0 = every register and the register file hold.
- `pc`  out  32  current fetch address in bytes.
- `fetch_instruction`  out  32  F/D instruction register, the instruction in decode.
- `decode_opcode`  out  7  opcode field of `fetch_instruction`.
- `alu_instruction`  out  32  D/E instruction register.
- `alu_src1`, `alu_src2`  out  32  D/E operand registers.
- `alu_result`  out  32  combinational ALU output.
- `wb_en`  out  1  register-file write this cycle.
- `wb_addr`  out  5  destination register of that write.

## Operation
- Instruction format:
  - opcode [31:25], rd [24:20], rs1 [19:15], rs2 [14:10].
  - imm15 [14:0], sign-extended to 32 bits.
- Opcodes:
  - 0x00 NOP.
  - 0x01 ADD, 0x02 SUB, 0x03 MUL (low 32 bits).
  - 0x04 AND, 0x05 OR, 0x06 XOR.
  - 0x07 SLL, 0x08 SRL, 0x09 SRA, shift amount is src2[4:0].
  - 0x0A SLT: signed compare, result 1 or 0.
  - 0x10 ADDI: src2 = sext(imm15).
- Any other opcode: result 0, no writeback.
- All arithmetic is modulo 2^32 with no flags.
- Fetch:
  - ROM word index = pc[log2(IMEM_DEPTH)+1:2], wrapping modulo depth.
  - pc increments by 4 each enabled cycle; the 32-bit value wraps at 0xFFFFFFFC → 0.
  - There are no branches.
- Decode:
  - src1 = R[rs1].
  - src2 = R[rs2], or sext(imm15) for ADDI.
  - R0 always reads 0, and writes to it are discarded.
- Forwarding: if the instruction in execute writes rd ≠ 0 and rd equals a decode source register, decode takes `alu_result` instead of the register-file value. There are no stalls for data hazards.
- Writeback:
  - `wb_en` = enable & valid opcode ≠ NOP & rd ≠ 0.
  - R[rd] ← `alu_result` at the clock edge ending execute.

## Timing
- Reset values:
  - pc = 0.
  - `fetch_instruction` = 0, `alu_instruction` = 0, `alu_src1` = 0, `alu_src2` = 0.
  - All registers R0–R31 = 0.
  - Hence `alu_result` = 0 and `wb_en` = 0.
- Reset has priority over `enable`. Reset mid-operation discards all in-flight instructions.
- For an instruction at address A, counting rising edges with enable=1 from when pc = A:
  - edge 1: F/D captures the instruction and pc becomes A+4.
  - edge 2: D/E captures the decoded operands; `alu_result` is valid immediately after this edge.
  - edge 3: the register-file write occurs.
- Throughput is one instruction per enabled cycle.
- With enable=0 nothing changes; the outputs stay stable, including combinational `alu_result`.
- Back-to-back dependent instructions produce correct results through forwarding.

## Structure
- Shared package `fdalu_pkg`:
  - opcode localparams.
  - field-position constants.
  - `XLEN` = 32.
- Sub-modules:
  - `alu`: combinational, inputs op, a and b; output result.
  - `regfile`: two read ports, one write port, synchronous reset.
- Fetch, decode and the pipeline registers stay in the top-level module.

## Test plan
- Reset then hold: assert reset for 2 cycles with enable=1 → pc=0, `alu_result`=0, `wb_en`=0. Hold enable=0 for 3 cycles → pc stays 0.
- ADDI chain:
  - program: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2.
  - ADD execute → `alu_src1`=5, `alu_src2`=0xFFFFFFFD (forwarded, back-to-back), `alu_result`=2, `wb_addr`=3.
- ALU ops with r1=0x0000F00F, r2=4:
  - SUB → 0x0000F00B.
  - MUL → 0x0003C03C.
  - AND → 4.
  - OR → 0x0000F00F.
  - XOR → 0x0000F00B.
  - SLL → 0x000F00F0.
  - SRL → 0x00000F00.
  - SLT r2,r1 → 1.
- SRA and R0 behaviour:
  - ADDI r1,r0,-16 then SRA r4,r1,r5 with r5=2 → 0xFFFFFFFC.
  - ADDI r0,r0,7 → `wb_en`=0, and a later read of r0 returns 0.
- Stall: deassert enable mid-program for 2 cycles → all outputs frozen, no writes. Program resumes with identical results.
- Illegal opcode 0x7F → `alu_result`=0, `wb_en`=0. With IMEM_DEPTH=4, pc=0x10 fetches word 0.

Source files
------------

// File: rtl/fdalu_pkg.sv
// rtl/fdalu_pkg.sv - shared opcodes, field positions and decode helpers for fetch_decode_alu
package fdalu_pkg;

    localparam int XLEN = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 25;
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 14;
    localparam int RS2_LSB = 10;
    localparam int IMM_MSB = 14;
    localparam int IMM_LSB = 0;

    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_MUL  = 7'h03;
    localparam logic [6:0] OP_AND  = 7'h04;
    localparam logic [6:0] OP_OR   = 7'h05;
    localparam logic [6:0] OP_XOR  = 7'h06;
    localparam logic [6:0] OP_SLL  = 7'h07;
    localparam logic [6:0] OP_SRL  = 7'h08;
    localparam logic [6:0] OP_SRA  = 7'h09;
    localparam logic [6:0] OP_SLT  = 7'h0A;
    localparam logic [6:0] OP_ADDI = 7'h10;

    function automatic logic [6:0] get_opcode(input logic [XLEN-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [4:0] get_rd(input logic [XLEN-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [XLEN-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [XLEN-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    function automatic logic [XLEN-1:0] get_imm(input logic [XLEN-1:0] instr);
        return {{(XLEN-IMM_MSB-1){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    endfunction

    // True for every opcode that produces a register result; NOP and unknown codes do not.
    function automatic logic op_writes(input logic [6:0] op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_ADDI: w = 1'b1;
            default:                                 w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fetch_decode_alu_alu.sv
// rtl/fetch_decode_alu_alu.sv - combinational integer ALU, modulo 2^32, no flags
module alu
    import fdalu_pkg::*;
(
    input  logic [6:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD, OP_ADDI: result = a + b;
            OP_SUB:          result = a - b;
            OP_MUL:          result = a * b;
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_XOR:          result = a ^ b;
            OP_SLL:          result = a << shamt;
            OP_SRL:          result = a >> shamt;
            OP_SRA:          result = $signed(a) >>> shamt;
            OP_SLT:          result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_alu_regfile.sv
// rtl/fetch_decode_alu_regfile.sv - 32x32 register file, two read ports, one write port, R0 hardwired to 0
module regfile
    import fdalu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/fetch_decode_alu.sv
// rtl/fetch_decode_alu.sv - three-stage fetch/decode/execute front end with forwarding and global stall
module fetch_decode_alu
    import fdalu_pkg::*;
#(
    parameter int    IMEM_DEPTH = 256,
    parameter string IMEM_INIT  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] pc,
    output logic [31:0] fetch_instruction,
    output logic [6:0]  decode_opcode,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [31:0] alu_result,
    output logic        wb_en,
    output logic [4:0]  wb_addr
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] rom [IMEM_DEPTH] = '{default: '0};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fd_instr_q, fd_instr_d;
    logic [XLEN-1:0] de_instr_q, de_instr_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;

    logic [IDX_W-1:0] fetch_idx;
    logic [4:0]       fd_rs1, fd_rs2;
    logic [6:0]       fd_op, ex_op;
    logic [4:0]       ex_rd;
    logic             ex_writes;
    logic [XLEN-1:0]  rf_rdata1, rf_rdata2;
    logic [XLEN-1:0]  alu_result_w;

    // Word index drops the byte offset and wraps modulo the ROM depth.
    assign fetch_idx  = pc_q[IDX_W+1:2];
    assign pc_d       = pc_q + 32'd4;
    assign fd_instr_d = rom[fetch_idx];
    assign de_instr_d = fd_instr_q;

    assign fd_op     = get_opcode(fd_instr_q);
    assign fd_rs1    = get_rs1(fd_instr_q);
    assign fd_rs2    = get_rs2(fd_instr_q);
    assign ex_op     = get_opcode(de_instr_q);
    assign ex_rd     = get_rd(de_instr_q);
    assign ex_writes = op_writes(ex_op) && (ex_rd != 5'd0);

    regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_en),
        .waddr_i  (ex_rd),
        .wdata_i  (alu_result_w),
        .raddr1_i (fd_rs1),
        .raddr2_i (fd_rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    alu u_alu (
        .op     (ex_op),
        .a      (src1_q),
        .b      (src2_q),
        .result (alu_result_w)
    );

    // The execute-stage result bypasses the register file so back-to-back dependents never stall.
    always_comb begin
        src1_d = rf_rdata1;
        src2_d = rf_rdata2;
        if (ex_writes && (ex_rd == fd_rs1)) begin
            src1_d = alu_result_w;
        end
        if (fd_op == OP_ADDI) begin
            src2_d = get_imm(fd_instr_q);
        end else if (ex_writes && (ex_rd == fd_rs2)) begin
            src2_d = alu_result_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            fd_instr_q <= '0;
            de_instr_q <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
        end else if (enable) begin
            pc_q       <= pc_d;
            fd_instr_q <= fd_instr_d;
            de_instr_q <= de_instr_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
        end
    end

    assign pc                = pc_q;
    assign fetch_instruction = fd_instr_q;
    assign decode_opcode     = fd_op;
    assign alu_instruction   = de_instr_q;
    assign alu_src1          = src1_q;
    assign alu_src2          = src2_q;
    assign alu_result        = alu_result_w;
    assign wb_en             = enable & ex_writes;
    assign wb_addr           = ex_rd;

endmodule

// File: tb/tb_fetch_decode_alu.sv
// tb/tb_fetch_decode_alu.sv - self-checking bench for fetch_decode_alu
module tb_fetch_decode_alu;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b1;

    logic [31:0] pc, fetch_instruction, alu_instruction, alu_src1, alu_src2, alu_result;
    logic [6:0]  decode_opcode;
    logic        wb_en;
    logic [4:0]  wb_addr;

    logic [31:0] pc4, fi4, ai4, s14, s24, res4;
    logic [6:0]  dop4;
    logic        wben4;
    logic [4:0]  wba4;

    fetch_decode_alu #(.IMEM_DEPTH(256), .IMEM_INIT("")) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pc(pc), .fetch_instruction(fetch_instruction), .decode_opcode(decode_opcode),
        .alu_instruction(alu_instruction), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .wb_en(wb_en), .wb_addr(wb_addr)
    );

    fetch_decode_alu #(.IMEM_DEPTH(4), .IMEM_INIT("")) dut4 (
        .clk(clk), .reset(reset), .enable(enable),
        .pc(pc4), .fetch_instruction(fi4), .decode_opcode(dop4),
        .alu_instruction(ai4), .alu_src1(s14), .alu_src2(s24),
        .alu_result(res4), .wb_en(wben4), .wb_addr(wba4)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog   [256];
    logic [31:0] regs_m [32];
    int          n_m    = 0;
    bit          chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {op, 5'(rd), 5'(rs1), 5'(rs2), 10'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int rs1, input int imm);
        return {op, 5'(rd), 5'(rs1), 15'(imm)};
    endfunction

    function automatic bit model_writes(input logic [6:0] op);
        return ((op >= 7'h01) && (op <= 7'h0A)) || (op == 7'h10);
    endfunction

    function automatic logic [31:0] model_alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            7'h01, 7'h10: return a + b;
            7'h02:        return a - b;
            7'h03:        return a * b;
            7'h04:        return a & b;
            7'h05:        return a | b;
            7'h06:        return a ^ b;
            7'h07:        return a << sh;
            7'h08:        return a >> sh;
            7'h09:        return $signed(a) >>> sh;
            7'h0A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:      return 32'd0;
        endcase
    endfunction

    // Sequential-semantics view of the instruction currently in execute.
    task automatic model_ex(output logic [31:0] fi, output logic [31:0] ai, output logic [31:0] s1,
                            output logic [31:0] s2, output logic [31:0] r, output bit wr, output logic [4:0] rd);
        logic [6:0] op;
        fi = (n_m >= 1) ? prog[8'((n_m - 1) % 256)] : 32'd0;
        ai = (n_m >= 2) ? prog[8'((n_m - 2) % 256)] : 32'd0;
        op = ai[31:25];
        rd = ai[24:20];
        s1 = regs_m[ai[19:15]];
        s2 = (op == 7'h10) ? {{17{ai[14]}}, ai[14:0]} : regs_m[ai[14:10]];
        r  = model_alu(op, s1, s2);
        wr = model_writes(op) && (rd != 5'd0);
    endtask

    initial forever begin
        logic [31:0] fi, ai, s1, s2, r;
        bit          wr;
        logic [4:0]  rd;
        @(posedge clk);
        if (reset) begin
            n_m = 0;
            for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
            chk_on = 1'b1;
        end else if (enable) begin
            model_ex(fi, ai, s1, s2, r, wr, rd);
            if (wr) regs_m[rd] = r;
            n_m++;
        end
    end

    initial forever begin
        logic [31:0] fi, ai, s1, s2, r;
        bit          wr;
        logic [4:0]  rd;
        @(negedge clk);
        if (chk_on) begin
            model_ex(fi, ai, s1, s2, r, wr, rd);
            chk("pc", pc, 32'(4 * n_m));
            chk("fetch_instruction", fetch_instruction, fi);
            chk("decode_opcode", 32'(decode_opcode), 32'(fi[31:25]));
            chk("alu_instruction", alu_instruction, ai);
            chk("alu_src1", alu_src1, s1);
            chk("alu_src2", alu_src2, s2);
            chk("alu_result", alu_result, r);
            chk("wb_en", 32'(wb_en), 32'(enable & wr));
            chk("wb_addr", 32'(wb_addr), 32'(rd));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
        prog[0]  = enc_i(7'h10, 1, 0, 5);
        prog[1]  = enc_i(7'h10, 2, 0, -3);
        prog[2]  = enc_r(7'h01, 3, 1, 2);
        prog[3]  = enc_i(7'h10, 7, 0, 2);
        prog[4]  = enc_i(7'h10, 1, 0, 32'h3C03);
        prog[5]  = enc_r(7'h07, 1, 1, 7);
        prog[6]  = enc_i(7'h10, 1, 1, 3);
        prog[7]  = enc_i(7'h10, 2, 0, 4);
        prog[8]  = enc_r(7'h02, 8, 1, 2);
        prog[9]  = enc_r(7'h03, 9, 1, 2);
        prog[10] = enc_r(7'h04, 10, 1, 2);
        prog[11] = enc_r(7'h05, 11, 1, 2);
        prog[12] = enc_r(7'h06, 12, 1, 2);
        prog[13] = enc_r(7'h07, 13, 1, 2);
        prog[14] = enc_r(7'h08, 14, 1, 2);
        prog[15] = enc_r(7'h0A, 15, 2, 1);
        prog[16] = enc_i(7'h10, 1, 0, -16);
        prog[17] = enc_i(7'h10, 5, 0, 2);
        prog[18] = enc_r(7'h09, 4, 1, 5);
        prog[19] = enc_i(7'h10, 0, 0, 7);
        prog[20] = enc_r(7'h01, 6, 0, 0);
        prog[21] = enc_r(7'h7F, 3, 1, 2);
        prog[22] = enc_r(7'h01, 16, 3, 0);
        #1;
        for (int i = 0; i < 256; i++) dut.rom[i] = prog[i];
        dut4.rom[0] = 32'h2010_0001;
        dut4.rom[1] = 32'h2010_0002;
        dut4.rom[2] = 32'h2010_0003;
        dut4.rom[3] = 32'h2010_0004;

        cyc();
        cyc();
        chk("reset_pc", pc, 32'd0);
        chk("reset_alu_result", alu_result, 32'd0);
        chk("reset_wb_en", 32'(wb_en), 32'd0);
        chk("reset_fetch", fetch_instruction, 32'd0);

        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) cyc();
        chk("hold_pc", pc, 32'd0);
        chk("hold_wb_en", 32'(wb_en), 32'd0);
        enable = 1'b1;

        for (int m = 1; m <= 26; m++) begin
            cyc();
            case (m - 2)
                -1: chk("first_fetch", fetch_instruction, 32'h2010_0005);
                2: begin
                    chk("fwd_add_instr", alu_instruction, 32'h0230_8800);
                    chk("fwd_add_src1", alu_src1, 32'd5);
                    chk("fwd_add_src2", alu_src2, 32'hFFFF_FFFD);
                    chk("fwd_add_result", alu_result, 32'd2);
                    chk("fwd_add_wb_addr", 32'(wb_addr), 32'd3);
                    chk("fwd_add_wb_en", 32'(wb_en), 32'd1);
                end
                8:  chk("sub", alu_result, 32'h0000_F00B);
                9:  chk("mul", alu_result, 32'h0003_C03C);
                10: chk("and", alu_result, 32'h0000_0004);
                11: chk("or", alu_result, 32'h0000_F00F);
                12: chk("xor", alu_result, 32'h0000_F00B);
                13: chk("sll", alu_result, 32'h000F_00F0);
                14: chk("srl", alu_result, 32'h0000_0F00);
                15: chk("slt", alu_result, 32'h0000_0001);
                18: chk("sra", alu_result, 32'hFFFF_FFFC);
                19: chk("r0_write_wb_en", 32'(wb_en), 32'd0);
                20: begin
                    chk("r0_read_src1", alu_src1, 32'd0);
                    chk("r0_read_result", alu_result, 32'd0);
                end
                21: begin
                    chk("illegal_result", alu_result, 32'd0);
                    chk("illegal_wb_en", 32'(wb_en), 32'd0);
                end
                22: chk("illegal_no_write", alu_src1, 32'd2);
                default: ;
            endcase
            if (m == 4) chk("depth4_last_word", fi4, 32'h2010_0004);
            if (m == 5) begin
                chk("depth4_pc", pc4, 32'h0000_0014);
                chk("depth4_wrap_fetch", fi4, 32'h2010_0001);
                chk("depth4_result", res4, 32'd4);
            end
            if (m == 12) begin
                enable = 1'b0;
                cyc();
                cyc();
                chk("stall_pc", pc, 32'h0000_0030);
                chk("stall_result", alu_result, 32'h0000_0004);
                chk("stall_wb_en", 32'(wb_en), 32'd0);
                enable = 1'b1;
            end
        end

        reset = 1'b1;
        cyc();
        chk("midreset_pc", pc, 32'd0);
        chk("midreset_alu_instr", alu_instruction, 32'd0);
        chk("midreset_result", alu_result, 32'd0);
        reset = 1'b0;
        repeat (4) cyc();
        chk("rerun_add_result", alu_result, 32'd2);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
